// File: rtl/bram_rd_stream.sv
// bram_rd_stream
//   Replays a block of `len` words starting at `base` from a one-cycle-latency
//   BRAM read port as a valid/ready stream with full backpressure. Reads are
//   issued only while the 4-entry output FIFO plus in-flight reads has room,
//   so the FIFO can never overflow.
//
// Optional feature macro: BRAM_RD_STREAM_LAST_EN (adds m_last output).
//
// Ports
//   clk       clock (also clocks the RAM port)
//   rst       synchronous reset, active-high
//   start     1-cycle command pulse; ignored while busy
//   base      first word address
//   len       word count, 0..2**G_ADDR
//   busy      command in progress
//   done      1-cycle pulse after the final beat is accepted (or after len=0)
//   ram_addr  registered RAM read address
//   ram_dout  RAM registered read data, valid one cycle after ram_addr
//   m_valid / m_ready / m_data   output stream
//   m_last    (BRAM_RD_STREAM_LAST_EN only) final beat of the command

module bram_rd_stream #(
   parameter int unsigned G_ADDR  = 6,
   parameter int unsigned G_WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [G_ADDR-1:0]  base,
   input  logic [G_ADDR:0]    len,
   output logic               busy,
   output logic               done,
   output logic [G_ADDR-1:0]  ram_addr,
   input  logic [G_WIDTH-1:0] ram_dout,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [G_WIDTH-1:0] m_data
`ifdef BRAM_RD_STREAM_LAST_EN
   ,
   output logic               m_last
`endif
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [G_ADDR-1:0]  ram_addr_q, ram_addr_d;
   logic [G_ADDR:0]    issue_rem_q, issue_rem_d;  // reads still to issue
   logic [G_ADDR:0]    beat_rem_q, beat_rem_d;    // beats still to hand over
   logic               done_q, done_d;
   // v1: address on the RAM port this cycle; v2: ram_dout holds a wanted word
   logic               v1_q, v1_d, v2_q, v2_d;

   logic [G_WIDTH-1:0] mem_q [4];
   logic [G_WIDTH-1:0] mem_d [4];
   logic [1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]         cnt_q, cnt_d;

   logic               push, pop;
   logic [3:0]         occ;

`ifdef BRAM_RD_STREAM_LAST_EN
   logic               l1_q, l1_d, l2_q, l2_d;
   logic [3:0]         last_mem_q, last_mem_d;
`endif

   assign push = v2_q;
   assign pop  = (cnt_q != 3'd0) && m_ready;
   // Words that will occupy the FIFO once every outstanding read lands.
   assign occ  = {1'b0, cnt_q} + {3'b000, v1_q} + {3'b000, v2_q};

   always_comb begin
      state_d     = state_q;
      ram_addr_d  = ram_addr_q;
      issue_rem_d = issue_rem_q;
      beat_rem_d  = beat_rem_q;
      done_d      = 1'b0;
      v1_d        = 1'b0;
      v2_d        = v1_q;
`ifdef BRAM_RD_STREAM_LAST_EN
      l1_d        = 1'b0;
      l2_d        = l1_q;
`endif

      if (pop) begin
         beat_rem_d = beat_rem_q - (G_ADDR+1)'(1);
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  // First read goes out on the accepting edge.
                  ram_addr_d  = base;
                  v1_d        = 1'b1;
                  issue_rem_d = len - (G_ADDR+1)'(1);
                  beat_rem_d  = len;
                  state_d     = (len == (G_ADDR+1)'(1)) ? StDrain : StRun;
`ifdef BRAM_RD_STREAM_LAST_EN
                  l1_d        = (len == (G_ADDR+1)'(1));
`endif
               end
            end
         end
         StRun: begin
            if (occ < 4'd4) begin
               ram_addr_d  = ram_addr_q + G_ADDR'(1);
               v1_d        = 1'b1;
               issue_rem_d = issue_rem_q - (G_ADDR+1)'(1);
               if (issue_rem_q == (G_ADDR+1)'(1)) begin
                  state_d = StDrain;
`ifdef BRAM_RD_STREAM_LAST_EN
                  l1_d    = 1'b1;
`endif
               end
            end
         end
         StDrain: begin
            if (pop && beat_rem_q == (G_ADDR+1)'(1)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output FIFO; simultaneous push and pop leaves the count unchanged.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q + {2'b00, push} - {2'b00, pop};
`ifdef BRAM_RD_STREAM_LAST_EN
      last_mem_d = last_mem_q;
`endif
      if (push) begin
         mem_d[wr_ptr_q] = ram_dout;
         wr_ptr_d        = wr_ptr_q + 2'd1;
`ifdef BRAM_RD_STREAM_LAST_EN
         last_mem_d[wr_ptr_q] = l2_q;
`endif
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         ram_addr_q  <= '0;
         issue_rem_q <= '0;
         beat_rem_q  <= '0;
         done_q      <= 1'b0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         wr_ptr_q    <= 2'd0;
         rd_ptr_q    <= 2'd0;
         cnt_q       <= 3'd0;
         for (int i = 0; i < 4; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         ram_addr_q  <= ram_addr_d;
         issue_rem_q <= issue_rem_d;
         beat_rem_q  <= beat_rem_d;
         done_q      <= done_d;
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         mem_q       <= mem_d;
      end
   end

`ifdef BRAM_RD_STREAM_LAST_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         l1_q       <= 1'b0;
         l2_q       <= 1'b0;
         last_mem_q <= 4'd0;
      end else begin
         l1_q       <= l1_d;
         l2_q       <= l2_d;
         last_mem_q <= last_mem_d;
      end
   end

   assign m_last = m_valid && last_mem_q[rd_ptr_q];
`endif

   assign busy     = (state_q != StIdle);
   assign done     = done_q;
   assign ram_addr = ram_addr_q;
   assign m_valid  = (cnt_q != 3'd0);
   assign m_data   = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_bram_rd_stream.sv
module tb_bram_rd_stream;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 16;
   localparam int unsigned DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base;
   logic [AW:0]   len;
   logic          busy, done, m_valid, m_ready;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_dout, m_data;
`ifdef BRAM_RD_STREAM_LAST_EN
   logic          m_last;
`endif

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] ram [DEPTH];

   always #5 clk = ~clk;

   // Inferred-BRAM behaviour: registered read, no enable.
   always @(posedge clk) ram_dout <= ram[ram_addr];

   bram_rd_stream #(
      .G_ADDR  (AW),
      .G_WIDTH (DW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .base     (base),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .ram_addr (ram_addr),
      .ram_dout (ram_dout),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data)
`ifdef BRAM_RD_STREAM_LAST_EN
      ,
      .m_last   (m_last)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // mode 0: always ready; 1: toggle with a 10-cycle stall; 2: random ready.
   // extra_start: cycle at which a second start is pulsed (0 = none).
   // rst_beats: assert reset after this many beats (0 = none).
   task automatic run_cmd(input int b, input int l, input int mode,
                          input int extra_start, input int rst_beats);
      logic [DW-1:0] expq[$];
      logic [DW-1:0] prev_data;
      logic          stalled;
      int            cyc, beats, last_hs;
      bit            finished;
      for (int i = 0; i < l; i++) expq.push_back(ram[(b + i) % DEPTH]);
      @(posedge clk); #1;
      start = 1'b1;
      base  = AW'(b);
      len   = (AW+1)'(l);
      cyc = 0; beats = 0; last_hs = 0; stalled = 1'b0; prev_data = '0;
      finished = 1'b0;
      for (int k = 0; k < 600 && !finished; k++) begin
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
         if (extra_start != 0 && cyc == extra_start) begin
            start = 1'b1;
            base  = AW'(b + 7);
            len   = (AW+1)'(3);
         end
         case (mode)
            0: m_ready = 1'b1;
            1: m_ready = (cyc >= 8 && cyc < 18) ? 1'b0 : cyc[0];
            default: m_ready = ($urandom_range(0, 3) != 0);
         endcase
         @(negedge clk);
         if (cyc == 1) check("busy_after_start", {31'b0, busy}, {31'b0, (l != 0)});
         if (stalled) begin
            check("hold_valid", {31'b0, m_valid}, 32'd1);
            check("hold_data", {16'b0, m_data}, {16'b0, prev_data});
         end
         if (m_valid && beats == 0 && mode == 0) check("first_beat_cycle", cyc, 3);
         if (m_valid && m_ready) begin
            if (expq.size() == 0) begin
               check("extra_beat", beats, l);
            end else begin
               check("beat_data", {16'b0, m_data}, {16'b0, expq.pop_front()});
            end
`ifdef BRAM_RD_STREAM_LAST_EN
            check("m_last", {31'b0, m_last}, {31'b0, (beats == l - 1)});
`endif
            beats++;
            last_hs = cyc;
            if (rst_beats != 0 && beats == rst_beats) begin
               @(posedge clk); #1;
               rst = 1'b1;
               @(posedge clk); #1;
               rst = 1'b0;
               @(negedge clk);
               check("rst_m_valid", {31'b0, m_valid}, 32'd0);
               check("rst_busy", {31'b0, busy}, 32'd0);
               check("rst_ram_addr", {26'b0, ram_addr}, 32'd0);
               return;
            end
         end else if (m_valid) begin
`ifdef BRAM_RD_STREAM_LAST_EN
            check("m_last_hold", {31'b0, m_last}, {31'b0, (beats == l - 1)});
`endif
         end
         stalled   = m_valid && !m_ready;
         prev_data = m_data;
         if (done) begin
            check("done_cycle", cyc, (l == 0) ? 1 : last_hs + 1);
            check("beat_count", beats, l);
            check("busy_at_done", {31'b0, busy}, 32'd0);
            finished = 1'b1;
         end
      end
      if (!finished) check("timeout", 0, 1);
      // Nothing further may be streamed, and the extra start must have been dropped.
      m_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (m_valid || busy || done) check("idle_after_done", {29'b0, m_valid, busy, done}, 0);
      end
      check("idle_valid", {31'b0, m_valid}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base = '0; len = '0; m_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_m_valid", {31'b0, m_valid}, 32'd0);
      check("reset_m_data", {16'b0, m_data}, 32'd0);
      check("reset_ram_addr", {26'b0, ram_addr}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_cmd(0, 8, 0, 0, 0);
      run_cmd(62, 4, 0, 0, 0);
      run_cmd(5, 16, 1, 0, 0);
      run_cmd(9, 0, 0, 0, 0);
      run_cmd(20, 1, 0, 0, 0);
      run_cmd(30, 5, 2, 0, 0);
      run_cmd(10, 12, 0, 5, 0);
      run_cmd(40, 20, 0, 0, 3);
      run_cmd(1, 6, 0, 0, 0);
      run_cmd(60, 64, 2, 0, 0);

      for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
      for (int n = 0; n < 8; n++) begin
         run_cmd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), 2, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
